sram_axi_bridge: RTL and testbench
==================================

// Module: sram_axi_bridge
// PURPOSE
//  Responder for the core's two sram-like ports (inst, data): accepts req/addr_ok, returns data_ok/rdata.
//  Translates the requests into single-beat AXI3 master transactions toward the SoC crossbar.
//  Sits between mycpu_core and the AXI top wrapper.
// PARAMETERS
//  ID_W    4   AXI id width; inst reads use id 0, data reads/writes use id 1
//  ADDR_W  32  address width (data width fixed at 32)
// PORTS
//  aclk        in   1   clock
//  aresetn     in   1   asynchronous active-low reset
//  inst_sram_req/wr/size/wstrb/addr/wdata  in   1/1/2/4/32/32  inst request (wr must be 0)
//  inst_sram_addr_ok/data_ok               out  1/1            inst request accepted / read data returned
//  inst_sram_rdata                         out  32             inst read data, valid with data_ok
//  data_sram_req/wr/size/wstrb/addr/wdata  in   1/1/2/4/32/32  data request
//  data_sram_addr_ok/data_ok               out  1/1            data request accepted / response returned
//  data_sram_rdata                         out  32             data read data, valid with read data_ok
//  arid/araddr/arlen/arsize/arburst        out  ID_W/32/8/3/2  AR channel; also arlock 2, arcache 4, arprot 3
//  arvalid out 1 / arready in 1            AR handshake
//  rid/rdata/rresp/rlast/rvalid            in   ID_W/32/2/1/1  R channel; rready out 1
//  awid/awaddr/awlen/awsize/awburst        out  ID_W/32/8/3/2  AW channel; also awlock 2, awcache 4, awprot 3
//  awvalid out 1 / awready in 1            AW handshake
//  wid/wdata/wstrb/wlast/wvalid            out  ID_W/32/4/1/1  W channel; wready in 1
//  bid/bresp/bvalid in ID_W/2/1; bready out 1   B channel
// BEHAVIOUR
//  Reset (aresetn=0, async): arvalid=rready=awvalid=wvalid=bready=0, FSMs to IDLE, all regs 0.
//  Constants: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1, awid=wid=1.
//  arsize/awsize = {1'b0, size}. rresp/bresp ignored.
//  Read FSM R_IDLE -> R_AR -> R_R -> R_IDLE; at most one read outstanding in the whole bridge.
//   R_IDLE: data read (req & ~wr) wins over inst req. data_sram_addr_ok=1 when req & ~wr & ~raw_block.
//           inst_sram_addr_ok = inst_req & ~(data read accepted this cycle).
//           On accept latch id/addr/size -> R_AR.
//   R_AR: arvalid=1, fields from latch, held stable until arready -> R_R.
//   R_R: rready=1. On rvalid: rid==0 -> inst_sram_data_ok=1, rid==1 -> data_sram_data_ok=1; -> R_IDLE.
//        rdata passed combinationally.
//  Write FSM W_IDLE -> W_REQ -> W_B -> W_IDLE; one write outstanding.
//   W_IDLE: data_sram_addr_ok=1 when req & wr; latch addr/size/wstrb/wdata -> W_REQ.
//   W_REQ: awvalid and wvalid raised together; each drops independently on its own handshake (aw_done/w_done).
//          Both done -> W_B. AW and W handshake in same cycle is legal.
//   W_B: bready=1. On bvalid -> data_sram_data_ok=1 (write response), -> W_IDLE.
//  raw_block = write FSM != W_IDLE & latched waddr[31:2]==data_sram_addr[31:2].
//   Data read to the same word waits until the write's B completes.
//  Read data_ok (R channel) and write data_ok (B) may coincide for the data port only if the read and write
//   came from data port in issue order; the core issues in order, so priority for the data port is read data_ok,
//   with bready held 0 that cycle.
//  Output timing: addr_ok is combinational from req & FSM state; data_ok is combinational from rvalid/bvalid.
//   Minimum read latency is 3 cycles (accept -> AR -> R).
//  Reset mid-transaction: all state abandoned; outstanding AXI transfers are not completed.
// STRUCTURE
//  Shared package/header: FSM state encodings, AXI burst/size constants, ID_INST=0, ID_DATA=1.
//  The write-channel FSM is a natural sub-module: axi_wr_ch.
//  Read arbitration stays in the top module.
// TESTING
//  1. inst req addr 0x1c000000, arready=1, rvalid 2 cycles later with rdata 0x02800000 (rid 0)
//     -> araddr=0x1c000000, arid 0; inst_sram_data_ok once with rdata 0x02800000.
//  2. inst and data read req in same cycle -> data addr_ok=1, inst addr_ok=0; AR id 1 issued first;
//     inst issued after its R completes.
//  3. data write addr 0x100, wstrb 4'b0011, size 1; awready 1 cycle before wready
//     -> awvalid drops first, wvalid held, awsize=3'b001; data_ok only on bvalid.
//  4. write 0x200 outstanding, then data read 0x200 -> read addr_ok=0 until B done.
//     A read of 0x204 is accepted at once.
//  5. arvalid high with arready=0 for 5 cycles -> araddr/arid stable.
//  6. aresetn deasserted during R_R -> all valid/ready outputs 0 immediately; next req accepted from IDLE.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI3 bridge: FSM encodings,
// fixed AXI field values and the transaction ids used per core port.
package sram_axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam int         ID_INST        = 0;
    localparam int         ID_DATA        = 1;

    // sram size encodes bytes as 2^size, which is exactly AXI AxSIZE for <= 4 bytes
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side bus of the bridge, one instance per bridge.
// Handshake: a channel transfers on a rising aclk edge where valid && ready are both 1;
// the source holds valid and its payload stable until that edge, ready may change freely.
interface sram_axi_bridge_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_bridge_axi_wr_ch.sv
// Single-outstanding AXI3 write channel: latches one data-port write, drives AW and W
// independently until each has handshaken, then waits for the B response.
module sram_axi_bridge_axi_wr_ch
    import sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [3:0]        req_wstrb,
    input  logic [31:0]       req_wdata,
    input  logic              b_hold,
    output logic              busy,
    output logic              b_ok,
    output wr_state_t         state_dbg,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);
    wr_state_t  state, state_next;
    logic       aw_done, w_done;
    logic       aw_fin, w_fin;
    logic [1:0] size_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= W_IDLE;
        else          state <= state_next;
    end

    // A channel counts as finished if it handshook earlier or is handshaking now
    assign aw_fin = aw_done | (awvalid & awready);
    assign w_fin  = w_done  | (wvalid  & wready);

    always_comb begin
        state_next = state;
        case (state)
            W_IDLE:  if (start)            state_next = W_REQ;
            W_REQ:   if (aw_fin && w_fin)  state_next = W_B;
            W_B:     if (bvalid && !b_hold) state_next = W_IDLE;
            default:                       state_next = W_IDLE;
        endcase
    end

    always_comb begin
        awvalid   = (state == W_REQ) & ~aw_done;
        wvalid    = (state == W_REQ) & ~w_done;
        bready    = (state == W_B) & ~b_hold;
        busy      = (state != W_IDLE);
        b_ok      = bvalid & bready;
        state_dbg = state;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awaddr  <= '0;
            size_q  <= '0;
            wstrb   <= '0;
            wdata   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (start) begin
            awaddr  <= req_addr;
            size_q  <= req_size;
            wstrb   <= req_wstrb;
            wdata   <= req_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
        end
    end

    assign awsize = axi_size(size_q);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridge from the core's inst/data sram-like ports to single-beat AXI3 transactions.
// One read and one write may be outstanding at a time; reads are arbitrated here.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              inst_sram_req,
    input  logic              inst_sram_wr,
    input  logic [1:0]        inst_sram_size,
    input  logic [3:0]        inst_sram_wstrb,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic              inst_sram_addr_ok,
    output logic              inst_sram_data_ok,
    output logic [31:0]       inst_sram_rdata,

    input  logic              data_sram_req,
    input  logic              data_sram_wr,
    input  logic [1:0]        data_sram_size,
    input  logic [3:0]        data_sram_wstrb,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic              data_sram_addr_ok,
    output logic              data_sram_data_ok,
    output logic [31:0]       data_sram_rdata,

    sram_axi_bridge_if.master axi,

    output rd_state_t         rd_state_dbg,
    output wr_state_t         wr_state_dbg
);
    rd_state_t         rd_state, rd_next;
    logic [ID_W-1:0]   rd_id_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        rd_size_q;

    logic              wr_busy, wr_b_ok, wr_start;
    wr_state_t         wr_state;

    logic data_rd_req, raw_block, data_rd_acc, inst_acc, rd_acc;
    logic r_fire, data_rd_ok;

    assign data_rd_req = data_sram_req & ~data_sram_wr;
    // A read of the word a pending write targets must not overtake that write
    assign raw_block   = wr_busy & (axi.awaddr[ADDR_W-1:2] == data_sram_addr[ADDR_W-1:2]);
    assign data_rd_acc = (rd_state == R_IDLE) & data_rd_req & ~raw_block;
    assign inst_acc    = (rd_state == R_IDLE) & inst_sram_req & ~data_rd_acc;
    assign rd_acc      = data_rd_acc | inst_acc;
    assign wr_start    = (wr_state == W_IDLE) & data_sram_req & data_sram_wr;
    assign r_fire      = axi.rvalid & (rd_state == R_R);
    assign data_rd_ok  = r_fire & (axi.rid == ID_W'(ID_DATA));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rd_state <= R_IDLE;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (rd_acc)      rd_next = R_AR;
            R_AR:    if (axi.arready) rd_next = R_R;
            R_R:     if (axi.rvalid)  rd_next = R_IDLE;
            default:                  rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        axi.arvalid       = (rd_state == R_AR);
        axi.rready        = (rd_state == R_R);
        inst_sram_addr_ok = inst_acc;
        data_sram_addr_ok = data_rd_acc | wr_start;
        inst_sram_data_ok = r_fire & (axi.rid == ID_W'(ID_INST));
        data_sram_data_ok = data_rd_ok | wr_b_ok;
        rd_state_dbg      = rd_state;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_id_q   <= '0;
            rd_addr_q <= '0;
            rd_size_q <= '0;
        end else if (rd_acc) begin
            rd_id_q   <= data_rd_acc ? ID_W'(ID_DATA) : ID_W'(ID_INST);
            rd_addr_q <= data_rd_acc ? data_sram_addr : inst_sram_addr;
            rd_size_q <= data_rd_acc ? data_sram_size : inst_sram_size;
        end
    end

    assign axi.arid    = rd_id_q;
    assign axi.araddr  = rd_addr_q;
    assign axi.arsize  = axi_size(rd_size_q);
    assign axi.arlen   = AXI_LEN_SINGLE;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;

    assign inst_sram_rdata = axi.rdata;
    assign data_sram_rdata = axi.rdata;

    // Read response wins the data port's data_ok; B waits one cycle via b_hold
    sram_axi_bridge_axi_wr_ch #(.ADDR_W(ADDR_W)) u_wr_ch (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (wr_start),
        .req_addr  (data_sram_addr),
        .req_size  (data_sram_size),
        .req_wstrb (data_sram_wstrb),
        .req_wdata (data_sram_wdata),
        .b_hold    (data_rd_ok),
        .busy      (wr_busy),
        .b_ok      (wr_b_ok),
        .state_dbg (wr_state),
        .awaddr    (axi.awaddr),
        .awsize    (axi.awsize),
        .awvalid   (axi.awvalid),
        .awready   (axi.awready),
        .wdata     (axi.wdata),
        .wstrb     (axi.wstrb),
        .wvalid    (axi.wvalid),
        .wready    (axi.wready),
        .bvalid    (axi.bvalid),
        .bready    (axi.bready)
    );

    assign axi.awid    = ID_W'(ID_DATA);
    assign axi.wid     = ID_W'(ID_DATA);
    assign axi.awlen   = AXI_LEN_SINGLE;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.wlast   = 1'b1;
    assign wr_state_dbg = wr_state;

    // Inputs the bridge deliberately ignores (inst port is read-only, responses are never errored)
    logic unused_inputs;
    assign unused_inputs = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                             axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: drivers issue sram requests and AXI responses,
// a negedge monitor checks every AXI handshake and sram data_ok against expected queues.
module tb_sram_axi_bridge;
    import sram_axi_bridge_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    rd_state_t   rd_state_dbg;
    wr_state_t   wr_state_dbg;

    sram_axi_bridge_if #(.ID_W(4), .ADDR_W(32)) axi ();

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    sram_axi_bridge #(.ID_W(4), .ADDR_W(32)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .axi               (axi),
        .rd_state_dbg      (rd_state_dbg),
        .wr_state_dbg      (wr_state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected queues: AR/AW {id,addr,size}, W {id,data,strb,last}, responses by port
    logic [38:0] exp_ar_q[$];
    logic [38:0] exp_aw_q[$];
    logic [40:0] exp_w_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_drd_q[$];
    logic [31:0] exp_dwr_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge aclk) begin
        if (aresetn) begin
            if (inst_sram_data_ok) begin
                check("inst_resp_expected", 64'(exp_inst_q.size() != 0), 1);
                if (exp_inst_q.size() != 0) check("inst_rdata", inst_sram_rdata, exp_inst_q.pop_front());
            end
            if (data_sram_data_ok) begin
                if (axi.rvalid && axi.rid == 4'd1) begin
                    check("data_rd_resp_expected", 64'(exp_drd_q.size() != 0), 1);
                    if (exp_drd_q.size() != 0) check("data_rdata", data_sram_rdata, exp_drd_q.pop_front());
                end else begin
                    check("data_wr_resp_expected", 64'(exp_dwr_q.size() != 0), 1);
                    if (exp_dwr_q.size() != 0) void'(exp_dwr_q.pop_front());
                    check("data_wr_resp_on_bvalid", axi.bvalid, 1);
                end
            end
            if (axi.arvalid && axi.arready) begin
                check("ar_expected", 64'(exp_ar_q.size() != 0), 1);
                if (exp_ar_q.size() != 0) check("ar_id_addr_size", {axi.arid, axi.araddr, axi.arsize}, exp_ar_q.pop_front());
                check("ar_len_burst", {axi.arlen, axi.arburst}, {8'd0, 2'b01});
            end
            if (axi.awvalid && axi.awready) begin
                check("aw_expected", 64'(exp_aw_q.size() != 0), 1);
                if (exp_aw_q.size() != 0) check("aw_id_addr_size", {axi.awid, axi.awaddr, axi.awsize}, exp_aw_q.pop_front());
                check("aw_len_burst", {axi.awlen, axi.awburst}, {8'd0, 2'b01});
            end
            if (axi.wvalid && axi.wready) begin
                check("w_expected", 64'(exp_w_q.size() != 0), 1);
                if (exp_w_q.size() != 0) check("w_id_data_strb_last", {axi.wid, axi.wdata, axi.wstrb, axi.wlast}, exp_w_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_inst(input logic [31:0] a);
        inst_sram_req  = 1'b1;
        inst_sram_addr = a;
        inst_sram_size = 2'd2;
    endtask

    task automatic set_data(input logic wr, input logic [1:0] size, input logic [3:0] strb,
                            input logic [31:0] a, input logic [31:0] d);
        data_sram_req   = 1'b1;
        data_sram_wr    = wr;
        data_sram_size  = size;
        data_sram_wstrb = strb;
        data_sram_addr  = a;
        data_sram_wdata = d;
    endtask

    // Hold the request until addr_ok (bounded), then drop it after the accepting edge
    task automatic wait_accept(input bit is_data, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            ok = is_data ? data_sram_addr_ok : inst_sram_addr_ok;
        end
        check(name, ok, 1);
        @(posedge aclk);
        #1;
        if (is_data) data_sram_req = 1'b0;
        else         inst_sram_req = 1'b0;
    endtask

    task automatic wait_rready();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge aclk);
            seen = axi.rready;
        end
        check("rready_seen", seen, 1);
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input int delay);
        wait_rready();
        step();
        repeat (delay) step();
        axi.rvalid = 1'b1;
        axi.rid    = id;
        axi.rdata  = d;
        step();
        axi.rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        aresetn = 1'b0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        axi.arready = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0; axi.bid = 1; axi.bresp = 0; axi.bvalid = 0;

        #3;
        check("reset_valid_ready", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'b0);
        check("reset_rd_state", rd_state_dbg, R_IDLE);
        check("reset_wr_state", wr_state_dbg, W_IDLE);
        check("reset_araddr", axi.araddr, 0);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        step();

        // 1: single inst read
        axi.arready = 1'b1;
        exp_ar_q.push_back({4'd0, 32'h1c000000, 3'd2});
        exp_inst_q.push_back(32'h02800000);
        set_inst(32'h1c000000);
        wait_accept(0, "t1_inst_accept");
        r_beat(4'd0, 32'h02800000, 1);
        step();

        // 2: simultaneous inst and data reads, data wins
        exp_ar_q.push_back({4'd1, 32'h00001000, 3'd2});
        exp_ar_q.push_back({4'd0, 32'h1c000004, 3'd2});
        exp_drd_q.push_back(32'h11111111);
        exp_inst_q.push_back(32'h22222222);
        set_inst(32'h1c000004);
        set_data(0, 2'd2, 4'hf, 32'h00001000, 0);
        @(negedge aclk);
        check("t2_data_addr_ok", data_sram_addr_ok, 1);
        check("t2_inst_addr_ok", inst_sram_addr_ok, 0);
        step();
        data_sram_req = 1'b0;
        @(negedge aclk);
        check("t2_inst_held_off", inst_sram_addr_ok, 0);
        r_beat(4'd1, 32'h11111111, 0);
        wait_accept(0, "t2_inst_accept_after_r");
        r_beat(4'd0, 32'h22222222, 0);
        step();

        // 3: halfword write, AW handshakes a cycle before W
        exp_aw_q.push_back({4'd1, 32'h00000100, 3'b001});
        exp_w_q.push_back({4'd1, 32'hcafef00d, 4'b0011, 1'b1});
        exp_dwr_q.push_back(32'h00000100);
        set_data(1, 2'd1, 4'b0011, 32'h00000100, 32'hcafef00d);
        wait_accept(1, "t3_wr_accept");
        @(negedge aclk);
        check("t3_aw_w_raised", {axi.awvalid, axi.wvalid, data_sram_data_ok}, 3'b110);
        step();
        axi.awready = 1'b1;
        step();
        axi.awready = 1'b0;
        @(negedge aclk);
        check("t3_aw_dropped_w_held", {axi.awvalid, axi.wvalid, data_sram_data_ok}, 3'b010);
        step();
        axi.wready = 1'b1;
        step();
        axi.wready = 1'b0;
        @(negedge aclk);
        check("t3_wait_b", {axi.bready, axi.wvalid, data_sram_data_ok}, 3'b100);
        step();
        axi.bvalid = 1'b1;
        step();
        axi.bvalid = 1'b0;
        @(negedge aclk);
        check("t3_wr_idle", wr_state_dbg, W_IDLE);
        step();

        // 4: read-after-write hazard on the same word, neighbour word unaffected
        exp_aw_q.push_back({4'd1, 32'h00000200, 3'd2});
        exp_w_q.push_back({4'd1, 32'h12345678, 4'hf, 1'b1});
        exp_dwr_q.push_back(32'h00000200);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        set_data(1, 2'd2, 4'hf, 32'h00000200, 32'h12345678);
        wait_accept(1, "t4_wr_accept");
        step();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        set_data(0, 2'd2, 4'hf, 32'h00000200, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("t4_raw_blocked", data_sram_addr_ok, 0);
        end
        step();
        exp_ar_q.push_back({4'd1, 32'h00000204, 3'd2});
        exp_drd_q.push_back(32'h0a0a0a0a);
        set_data(0, 2'd2, 4'hf, 32'h00000204, 0);
        @(negedge aclk);
        check("t4_next_word_accept", data_sram_addr_ok, 1);
        step();
        data_sram_req = 1'b0;
        r_beat(4'd1, 32'h0a0a0a0a, 0);
        exp_ar_q.push_back({4'd1, 32'h00000200, 3'd2});
        exp_drd_q.push_back(32'h0b0b0b0b);
        set_data(0, 2'd2, 4'hf, 32'h00000200, 0);
        @(negedge aclk);
        check("t4_still_blocked", data_sram_addr_ok, 0);
        step();
        axi.bvalid = 1'b1;
        step();
        axi.bvalid = 1'b0;
        wait_accept(1, "t4_read_after_b");
        r_beat(4'd1, 32'h0b0b0b0b, 0);
        step();

        // 5: AR stalled by arready low
        axi.arready = 1'b0;
        exp_ar_q.push_back({4'd0, 32'h1c000040, 3'd2});
        exp_inst_q.push_back(32'h33333333);
        set_inst(32'h1c000040);
        wait_accept(0, "t5_inst_accept");
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("t5_ar_stable", {axi.arvalid, axi.arid, axi.araddr}, {1'b1, 4'd0, 32'h1c000040});
        end
        step();
        axi.arready = 1'b1;
        r_beat(4'd0, 32'h33333333, 0);
        step();

        // 6: reset while waiting for R, then a fresh request
        exp_ar_q.push_back({4'd0, 32'h1c000080, 3'd2});
        set_inst(32'h1c000080);
        wait_accept(0, "t6_inst_accept");
        wait_rready();
        #2 aresetn = 1'b0;
        #1;
        check("t6_reset_valid_ready", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'b0);
        check("t6_reset_rd_state", rd_state_dbg, R_IDLE);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        exp_ar_q.push_back({4'd1, 32'h00000300, 3'd2});
        exp_drd_q.push_back(32'h44444444);
        set_data(0, 2'd2, 4'hf, 32'h00000300, 0);
        wait_accept(1, "t6_accept_after_reset");
        r_beat(4'd1, 32'h44444444, 0);
        step();

        // 7: read R and write B land together; read response first, B one cycle later
        exp_aw_q.push_back({4'd1, 32'h00000400, 3'd2});
        exp_w_q.push_back({4'd1, 32'h55555555, 4'hf, 1'b1});
        exp_dwr_q.push_back(32'h00000400);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        set_data(1, 2'd2, 4'hf, 32'h00000400, 32'h55555555);
        wait_accept(1, "t7_wr_accept");
        step();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        exp_ar_q.push_back({4'd1, 32'h00000500, 3'd2});
        exp_drd_q.push_back(32'h66666666);
        set_data(0, 2'd2, 4'hf, 32'h00000500, 0);
        wait_accept(1, "t7_rd_accept");
        wait_rready();
        step();
        axi.rvalid = 1'b1;
        axi.rid    = 4'd1;
        axi.rdata  = 32'h66666666;
        axi.bvalid = 1'b1;
        @(negedge aclk);
        check("t7_bready_held", {axi.bready, data_sram_data_ok}, 2'b01);
        step();
        axi.rvalid = 1'b0;
        @(negedge aclk);
        check("t7_b_after_r", {axi.bready, data_sram_data_ok}, 2'b11);
        step();
        axi.bvalid = 1'b0;
        repeat (3) step();

        check("left_ar", exp_ar_q.size(), 0);
        check("left_aw", exp_aw_q.size(), 0);
        check("left_w", exp_w_q.size(), 0);
        check("left_inst", exp_inst_q.size(), 0);
        check("left_data_rd", exp_drd_q.size(), 0);
        check("left_data_wr", exp_dwr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
